alu_shift_addr_datapath: RTL and testbench

ALU_SHIFT_ADDR_DATAPATH -- requirements
Module: alu_shift_addr_datapath

---
 rtl/alu_shift_addr_datapath.sv | 130 +++++++++++++
 tb/tb_alu_shift_addr_datapath.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_addr_datapath.sv
// Barrel shifter + ALU with registered result/NZCV flags, plus a word-stepping address register.
// Optional macro BARREL_RRX_EN turns shifter mode 4 into rotate-right-extended through carry.
module alu_shift_addr_datapath (
  input  logic        clk1,
  input  logic        rst,
  input  logic [31:0] bus_a,
  input  logic [31:0] bus_b,
  input  logic [2:0]  shifter_mode,
  input  logic [4:0]  shifter_count,
  input  logic        invert_a,
  input  logic        invert_b,
  input  logic        is_logic,
  input  logic [2:0]  logic_idx,
  input  logic        cin,
  input  logic        alu_active,
  input  logic        ale,
  input  logic        ar_inc,
  input  logic        abe,
  input  logic [31:0] alubus,
  output logic [31:0] shifter_output,
  output logic [31:0] alu_result,
  output logic        alu_n,
  output logic        alu_z,
  output logic        alu_c,
  output logic        alu_v,
  output logic [31:0] ar,
  output logic [31:0] incrementerbus
);

  logic [31:0] sh_out;
  logic        sh_carry;
  logic [63:0] ror_wide;
  logic [31:0] a_op;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic [31:0] nxt_result;
  logic        nxt_c;
  logic        nxt_v;
  logic [31:0] ar_q;

  assign ror_wide = {bus_b, bus_b} >> shifter_count;

  // Count 0 leaves the operand untouched and forwards the current carry flag.
  always_comb begin
    sh_out   = bus_b;
    sh_carry = alu_c;
    case (shifter_mode)
      3'd0: if (shifter_count != 5'd0) begin
        sh_out   = bus_b << shifter_count;
        sh_carry = bus_b[5'd0 - shifter_count];
      end
      3'd1: if (shifter_count != 5'd0) begin
        sh_out   = bus_b >> shifter_count;
        sh_carry = bus_b[shifter_count - 5'd1];
      end
      3'd2: if (shifter_count != 5'd0) begin
        sh_out   = 32'($signed(bus_b) >>> shifter_count);
        sh_carry = bus_b[shifter_count - 5'd1];
      end
      3'd3: if (shifter_count != 5'd0) begin
        sh_out   = ror_wide[31:0];
        sh_carry = bus_b[shifter_count - 5'd1];
      end
`ifdef BARREL_RRX_EN
      3'd4: begin
        sh_out   = {alu_c, bus_b[31:1]};
        sh_carry = bus_b[0];
      end
`else
      3'd4: begin
        sh_out   = bus_b;
        sh_carry = alu_c;
      end
`endif
      default: begin
        sh_out   = bus_b;
        sh_carry = alu_c;
      end
    endcase
  end

  assign shifter_output = sh_out;

  assign a_op = invert_a ? ~bus_a : bus_a;
  assign b_op = invert_b ? ~sh_out : sh_out;
  assign sum  = {1'b0, a_op} + {1'b0, b_op} + {32'd0, cin};

  always_comb begin
    nxt_result = sum[31:0];
    nxt_c      = sum[32];
    nxt_v      = (a_op[31] == b_op[31]) && (sum[31] != a_op[31]);
    if (is_logic) begin
      nxt_c = sh_carry;
      nxt_v = alu_v;
      case (logic_idx)
        3'd1:    nxt_result = a_op ^ b_op;
        3'd2:    nxt_result = a_op | b_op;
        3'd3:    nxt_result = b_op;
        default: nxt_result = a_op & b_op;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      alu_result <= 32'd0;
      alu_n      <= 1'b0;
      alu_z      <= 1'b0;
      alu_c      <= 1'b0;
      alu_v      <= 1'b0;
    end else if (alu_active) begin
      alu_result <= nxt_result;
      alu_n      <= nxt_result[31];
      alu_z      <= (nxt_result == 32'd0);
      alu_c      <= nxt_c;
      alu_v      <= nxt_v;
    end
  end

  // A direct load takes precedence over stepping to the next word.
  always_ff @(posedge clk1) begin
    if (rst)         ar_q <= 32'd0;
    else if (ale)    ar_q <= alubus;
    else if (ar_inc) ar_q <= incrementerbus;
  end

  assign incrementerbus = ar_q + 32'd4;
  assign ar             = abe ? ar_q : 32'd0;

endmodule

// File: tb/tb_alu_shift_addr_datapath.sv
// Directed-vector bench for alu_shift_addr_datapath; each task checks its own scenario inline.
module tb_alu_shift_addr_datapath;

  logic        clk1;
  logic        rst;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [2:0]  shifter_mode;
  logic [4:0]  shifter_count;
  logic        invert_a;
  logic        invert_b;
  logic        is_logic;
  logic [2:0]  logic_idx;
  logic        cin;
  logic        alu_active;
  logic        ale;
  logic        ar_inc;
  logic        abe;
  logic [31:0] alubus;
  logic [31:0] shifter_output;
  logic [31:0] alu_result;
  logic        alu_n;
  logic        alu_z;
  logic        alu_c;
  logic        alu_v;
  logic [31:0] ar;
  logic [31:0] incrementerbus;

  int errors = 0;
  int checks = 0;

  logic [2:0]  sh_mode [8];
  logic [4:0]  sh_cnt  [8];
  logic [31:0] sh_b    [8];
  logic [31:0] sh_exp  [8];
  logic [3:0]  sh_flg  [8];

  alu_shift_addr_datapath dut (
    .clk1(clk1), .rst(rst), .bus_a(bus_a), .bus_b(bus_b),
    .shifter_mode(shifter_mode), .shifter_count(shifter_count),
    .invert_a(invert_a), .invert_b(invert_b), .is_logic(is_logic),
    .logic_idx(logic_idx), .cin(cin), .alu_active(alu_active),
    .ale(ale), .ar_inc(ar_inc), .abe(abe), .alubus(alubus),
    .shifter_output(shifter_output), .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .ar(ar), .incrementerbus(incrementerbus)
  );

  // clock / reset
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; bus_a = '0; bus_b = '0; shifter_mode = '0; shifter_count = '0;
    invert_a = 1'b0; invert_b = 1'b0; is_logic = 1'b0; logic_idx = '0; cin = 1'b0;
    alu_active = 1'b0; ale = 1'b0; ar_inc = 1'b0; abe = 1'b1; alubus = '0;
  endtask

  task automatic drive_alu(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] mode, input logic [4:0] cnt,
                           input logic ia, input logic ib, input logic lg,
                           input logic [2:0] idx, input logic c);
    bus_a = a; bus_b = b; shifter_mode = mode; shifter_count = cnt;
    invert_a = ia; invert_b = ib; is_logic = lg; logic_idx = idx; cin = c;
    alu_active = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1; ale = 1'b1; alubus = 32'h55; alu_active = 1'b1; bus_a = 32'h9;
    tick();
    tick();
    drive_idle();
    #1;
    checks++;
    if (alu_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=%h", alu_result, 32'd0); end
    checks++;
    if ({alu_n, alu_z, alu_c, alu_v} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {alu_n, alu_z, alu_c, alu_v}); end
    checks++;
    if (ar !== 32'd0) begin errors++; $display("FAIL reset_ar got=%h exp=0", ar); end
    checks++;
    if (incrementerbus !== 32'd4) begin errors++; $display("FAIL reset_incbus got=%h exp=4", incrementerbus); end
  endtask

  task automatic test_add();
    drive_alu(32'd5, 32'h0F, 3'd3, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'h14) begin errors++; $display("FAIL add_result got=%h exp=14", alu_result); end
    checks++;
    if ({alu_n, alu_z, alu_c, alu_v} !== 4'b0000) begin errors++; $display("FAIL add_flags got=%b exp=0000", {alu_n, alu_z, alu_c, alu_v}); end
  endtask

  task automatic test_logic();
    drive_alu(32'd5, 32'd3, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'd1 || {alu_n, alu_z, alu_c, alu_v} !== 4'b0000) begin
      errors++; $display("FAIL and_op got=%h/%b exp=1/0000", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'd0, 32'h0F, 3'd3, 5'd4, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    #1;
    checks++;
    if (shifter_output !== 32'hF000_0000) begin errors++; $display("FAIL ror4_shift got=%h exp=f0000000", shifter_output); end
    tick();
    checks++;
    if (alu_result !== 32'hF000_0000 || {alu_n, alu_z, alu_c, alu_v} !== 4'b1010) begin
      errors++; $display("FAIL ror4_mov got=%h/%b exp=f0000000/1010", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'h1234, 32'h1234, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'd0 || {alu_n, alu_z, alu_c, alu_v} !== 4'b0110) begin
      errors++; $display("FAIL eor_zero got=%h/%b exp=0/0110", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'hF0, 32'h0F, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'hFF || {alu_n, alu_z, alu_c, alu_v} !== 4'b0010) begin
      errors++; $display("FAIL orr_op got=%h/%b exp=ff/0010", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'hFF, 32'h0F, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'h0F || {alu_n, alu_z, alu_c, alu_v} !== 4'b0010) begin
      errors++; $display("FAIL idx5_and got=%h/%b exp=f/0010", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
  endtask

  task automatic test_sub_overflow();
    drive_alu(32'd3, 32'd5, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    tick();
    checks++;
    if (alu_result !== 32'hFFFF_FFFE || {alu_n, alu_z, alu_c, alu_v} !== 4'b1000) begin
      errors++; $display("FAIL sub_op got=%h/%b exp=fffffffe/1000", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'h8000_0000 || {alu_n, alu_z, alu_c, alu_v} !== 4'b1001) begin
      errors++; $display("FAIL add_ovf got=%h/%b exp=80000000/1001", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'd0, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'd1 || {alu_n, alu_z, alu_c, alu_v} !== 4'b0001) begin
      errors++; $display("FAIL logic_keeps_v got=%h/%b exp=1/0001", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'hAAAA, 32'h5555, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    alu_active = 1'b0;
    tick();
    checks++;
    if (alu_result !== 32'd1 || {alu_n, alu_z, alu_c, alu_v} !== 4'b0001) begin
      errors++; $display("FAIL hold_inactive got=%h/%b exp=1/0001", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
  endtask

  task automatic test_shifter();
    // Clear V first so each MOV below has a known V of 0.
    drive_alu(32'd1, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    sh_mode[0] = 3'd0; sh_cnt[0] = 5'd4;  sh_b[0] = 32'h1800_0001; sh_exp[0] = 32'h8000_0010; sh_flg[0] = 4'b1010;
    sh_mode[1] = 3'd1; sh_cnt[1] = 5'd1;  sh_b[1] = 32'h0000_0003; sh_exp[1] = 32'h0000_0001; sh_flg[1] = 4'b0010;
    sh_mode[2] = 3'd2; sh_cnt[2] = 5'd4;  sh_b[2] = 32'h8000_0010; sh_exp[2] = 32'hF800_0001; sh_flg[2] = 4'b1000;
    sh_mode[3] = 3'd6; sh_cnt[3] = 5'd7;  sh_b[3] = 32'h1234_5678; sh_exp[3] = 32'h1234_5678; sh_flg[3] = 4'b0000;
    sh_mode[4] = 3'd3; sh_cnt[4] = 5'd8;  sh_b[4] = 32'h0000_00A5; sh_exp[4] = 32'hA500_0000; sh_flg[4] = 4'b1010;
    sh_mode[5] = 3'd1; sh_cnt[5] = 5'd31; sh_b[5] = 32'h8000_0000; sh_exp[5] = 32'h0000_0001; sh_flg[5] = 4'b0000;
    sh_mode[6] = 3'd0; sh_cnt[6] = 5'd31; sh_b[6] = 32'h0000_0003; sh_exp[6] = 32'h8000_0000; sh_flg[6] = 4'b1010;
    sh_mode[7] = 3'd2; sh_cnt[7] = 5'd0;  sh_b[7] = 32'h8000_0000; sh_exp[7] = 32'h8000_0000; sh_flg[7] = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      drive_alu(32'd0, sh_b[i], sh_mode[i], sh_cnt[i], 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
      #1;
      checks++;
      if (shifter_output !== sh_exp[i]) begin
        errors++; $display("FAIL shift_out[%0d] got=%h exp=%h", i, shifter_output, sh_exp[i]);
      end
      tick();
      checks++;
      if (alu_result !== sh_exp[i] || {alu_n, alu_z, alu_c, alu_v} !== sh_flg[i]) begin
        errors++; $display("FAIL shift_mov[%0d] got=%h/%b exp=%h/%b", i, alu_result,
                           {alu_n, alu_z, alu_c, alu_v}, sh_exp[i], sh_flg[i]);
      end
    end
  endtask

  task automatic test_rrx();
    logic [31:0] exp_out;
    logic [3:0]  exp_flg;
`ifdef BARREL_RRX_EN
    exp_out = 32'h8000_0001; exp_flg = 4'b1010;
`else
    exp_out = 32'h0000_0003; exp_flg = 4'b0010;
`endif
    drive_alu(32'hFFFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    checks++;
    if (alu_result !== 32'd0 || {alu_n, alu_z, alu_c, alu_v} !== 4'b0110) begin
      errors++; $display("FAIL carry_setup got=%h/%b exp=0/0110", alu_result, {alu_n, alu_z, alu_c, alu_v});
    end
    drive_alu(32'd0, 32'd3, 3'd4, 5'd5, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    #1;
    checks++;
    if (shifter_output !== exp_out) begin errors++; $display("FAIL mode4_shift got=%h exp=%h", shifter_output, exp_out); end
    tick();
    checks++;
    if (alu_result !== exp_out || {alu_n, alu_z, alu_c, alu_v} !== exp_flg) begin
      errors++; $display("FAIL mode4_mov got=%h/%b exp=%h/%b", alu_result, {alu_n, alu_z, alu_c, alu_v}, exp_out, exp_flg);
    end
  endtask

  task automatic test_addr();
    drive_idle();
    ale = 1'b1; alubus = 32'h100;
    tick();
    ale = 1'b0; ar_inc = 1'b1;
    tick();
    tick();
    ar_inc = 1'b0;
    #1;
    checks++;
    if (ar !== 32'h108) begin errors++; $display("FAIL ar_inc2 got=%h exp=108", ar); end
    checks++;
    if (incrementerbus !== 32'h10C) begin errors++; $display("FAIL incbus got=%h exp=10c", incrementerbus); end
    abe = 1'b0;
    #1;
    checks++;
    if (ar !== 32'd0) begin errors++; $display("FAIL abe_off got=%h exp=0", ar); end
    abe = 1'b1; ale = 1'b1; ar_inc = 1'b1; alubus = 32'h200;
    tick();
    ale = 1'b0; ar_inc = 1'b0;
    tick();
    checks++;
    if (ar !== 32'h200) begin errors++; $display("FAIL ale_priority got=%h exp=200", ar); end
    ale = 1'b1; alubus = 32'hFFFF_FFFC;
    tick();
    ale = 1'b0;
    checks++;
    if (incrementerbus !== 32'd0) begin errors++; $display("FAIL inc_wrap_bus got=%h exp=0", incrementerbus); end
    ar_inc = 1'b1;
    tick();
    ar_inc = 1'b0;
    checks++;
    if (ar !== 32'd0 || incrementerbus !== 32'd4) begin
      errors++; $display("FAIL ar_wrap got=%h/%h exp=0/4", ar, incrementerbus);
    end
  endtask

  task automatic test_reset_override();
    drive_alu(32'd5, 32'h0F, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    ale = 1'b1; alubus = 32'h300;
    tick();
    checks++;
    if (alu_result !== 32'h14 || ar !== 32'h300) begin
      errors++; $display("FAIL pre_reset got=%h/%h exp=14/300", alu_result, ar);
    end
    rst = 1'b1; ar_inc = 1'b1; bus_a = 32'hFFFF_FFFF; bus_b = 32'd1;
    tick();
    checks++;
    if (alu_result !== 32'd0 || {alu_n, alu_z, alu_c, alu_v} !== 4'b0000 || ar !== 32'd0 || incrementerbus !== 32'd4) begin
      errors++; $display("FAIL reset_override got=%h/%b/%h/%h exp=0/0000/0/4", alu_result,
                         {alu_n, alu_z, alu_c, alu_v}, ar, incrementerbus);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_add();
    test_logic();
    test_sub_overflow();
    test_shifter();
    test_rrx();
    test_addr();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
